alu_issue_ctrl: RTL and testbench

Command-issue and result-capture stage wrapped around the 8-bit combinational ALU. It accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO. It presents the head command to the ALU, registers the ALU result together with status flags, and hands the result downstream over a second valid/ready handshake. The ALU is instantiated beside this block in the parent and connected through the `ALU_*` ports.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 56 +++++
 rtl/alu_issue_ctrl.sv | 113 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and opcode constants for the ALU issue/capture slice.
// Consumed by alu_cmd_fifo and alu_issue_ctrl.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  localparam logic [SEL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [SEL_W-1:0] ALU_SUB = 3'b001;
  localparam logic [SEL_W-1:0] ALU_AND = 3'b010;
  localparam logic [SEL_W-1:0] ALU_OR  = 3'b011;
  localparam logic [SEL_W-1:0] ALU_NOT = 3'b100;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
  } cmd_t;

  function automatic logic is_illegal(
    input logic [SEL_W-1:0] sel
  );
    return sel > ALU_NOT;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Power-of-two command FIFO; pointers wrap naturally.
// Full FIFO never bypasses, even on a same-cycle pop.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   push_i,
  input  cmd_t                   din_i,
  input  logic                   pop_i,
  output cmd_t                   head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic          push;
  logic          pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign push    = push_i && !full_o;
  assign pop     = pop_i && !empty_o;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage around the external ALU: command FIFO, output register FSM.
// ALU_ISSUE_STATS_EN adds the saturating OP_COUNT handshake counter.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_A,
  input  logic [DATA_W-1:0] IN_B,
  input  logic [SEL_W-1:0]  IN_SEL,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [SEL_W-1:0]  ALU_SEL,
  input  logic [DATA_W-1:0] ALU_RESULT,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_RESULT,
  output logic [SEL_W-1:0]  OUT_SEL,
  output logic              OUT_ZERO,
  output logic              OUT_ILLEGAL
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]       OP_COUNT
`endif
);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  cmd_t                  head;
  cmd_t                  din;
  logic [$clog2(DEPTH):0] count;
  logic                  full;
  logic                  empty;
  logic                  capture;
  logic [0:0]            state_q, state_d;
  logic [DATA_W-1:0]     res_q;
  logic [SEL_W-1:0]      sel_q;
  logic                  zero_q;
  logic                  ill_q;

  assign din      = '{a: IN_A, b: IN_B, sel: IN_SEL};
  assign IN_READY = !full;
  assign capture  = (count != '0) && (state_q == S_EMPTY || OUT_READY);

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push_i  (IN_VALID && IN_READY),
    .din_i   (din),
    .pop_i   (capture),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign ALU_A   = empty ? '0 : head.a;
  assign ALU_B   = empty ? '0 : head.b;
  assign ALU_SEL = empty ? '0 : head.sel;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      capture:                                 state_d = S_FULL;
      (state_q == S_FULL && OUT_READY && empty): state_d = S_EMPTY;
      default:                                 state_d = state_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_EMPTY;
      res_q   <= '0;
      sel_q   <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        res_q  <= ALU_RESULT;
        sel_q  <= ALU_SEL;
        zero_q <= (ALU_RESULT == '0);
        ill_q  <= is_illegal(ALU_SEL);
      end
    end
  end

  assign OUT_VALID   = (state_q == S_FULL);
  assign OUT_RESULT  = res_q;
  assign OUT_SEL     = sel_q;
  assign OUT_ZERO    = zero_q;
  assign OUT_ILLEGAL = ill_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_cnt_q <= '0;
    end else if (OUT_VALID && OUT_READY && op_cnt_q != 16'hFFFF) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign OP_COUNT = op_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU beside it.
// Stats checks run only when ALU_ISSUE_STATS_EN is defined.
module tb_alu_issue_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_A, IN_B;
  logic [2:0] IN_SEL;
  logic [7:0] ALU_A, ALU_B;
  logic [2:0] ALU_SEL;
  logic [7:0] ALU_RESULT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_RESULT;
  logic [2:0] OUT_SEL;
  logic       OUT_ZERO;
  logic       OUT_ILLEGAL;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] OP_COUNT;
`endif

  int checks   = 0;
  int failures = 0;
  int accepted;
  logic [7:0] expq[$];

  always #5 CLK = ~CLK;

  always_comb begin
    ALU_RESULT = 8'h00;
    case (ALU_SEL)
      3'b000:  ALU_RESULT = ALU_A + ALU_B;
      3'b001:  ALU_RESULT = ALU_A - ALU_B;
      3'b010:  ALU_RESULT = ALU_A & ALU_B;
      3'b011:  ALU_RESULT = ALU_A | ALU_B;
      3'b100:  ALU_RESULT = ~ALU_A;
      default: ALU_RESULT = 8'h00;
    endcase
  end

  alu_issue_ctrl #(.DEPTH(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .IN_A        (IN_A),
    .IN_B        (IN_B),
    .IN_SEL      (IN_SEL),
    .ALU_A       (ALU_A),
    .ALU_B       (ALU_B),
    .ALU_SEL     (ALU_SEL),
    .ALU_RESULT  (ALU_RESULT),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .OUT_RESULT  (OUT_RESULT),
    .OUT_SEL     (OUT_SEL),
    .OUT_ZERO    (OUT_ZERO),
    .OUT_ILLEGAL (OUT_ILLEGAL)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .OP_COUNT    (OP_COUNT)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] sel);
    IN_A     = a;
    IN_B     = b;
    IN_SEL   = sel;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
  endtask

  initial begin
    RST_N     = 1'b0;
    IN_VALID  = 1'b0;
    IN_A      = '0;
    IN_B      = '0;
    IN_SEL    = '0;
    OUT_READY = 1'b0;
    #12;
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_result", OUT_RESULT, 0);
    chk("rst_alu_a", ALU_A, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    // single ADD
    OUT_READY = 1'b1;
    send(8'h0F, 8'h01, 3'b000);
    chk("add_alu_a", ALU_A, 8'h0F);
    chk("add_not_yet_valid", OUT_VALID, 0);
    tick();
    chk("add_valid", OUT_VALID, 1);
    chk("add_result", OUT_RESULT, 8'h10);
    chk("add_zero", OUT_ZERO, 0);
    chk("add_sel", OUT_SEL, 3'b000);
    tick();
    chk("add_drained", OUT_VALID, 0);

    // wrap and zero flag
    send(8'h05, 8'h05, 3'b001);
    tick();
    chk("sub_zero_result", OUT_RESULT, 8'h00);
    chk("sub_zero_flag", OUT_ZERO, 1);
    tick();
    send(8'h00, 8'h01, 3'b001);
    tick();
    chk("sub_wrap_result", OUT_RESULT, 8'hFF);
    chk("sub_wrap_zero", OUT_ZERO, 0);
    tick();

    // backpressure: 6 offered, 5 accepted
    OUT_READY = 1'b0;
    accepted  = 0;
    for (int i = 0; i < 6; i++) begin
      logic acc;
      IN_A     = 8'h10 + 8'(i);
      IN_B     = 8'(i);
      IN_SEL   = 3'b000;
      IN_VALID = 1'b1;
      acc      = IN_READY;
      tick();
      if (acc) begin
        accepted++;
        expq.push_back(8'h10 + 8'(2 * i));
      end
    end
    IN_VALID = 1'b0;
    chk("bp_accepted", accepted, 5);
    chk("bp_in_ready_low", IN_READY, 0);
    chk("bp_hold_valid", OUT_VALID, 1);
    chk("bp_hold_result", OUT_RESULT, 8'h10);
    tick();
    chk("bp_stable_result", OUT_RESULT, 8'h10);
    OUT_READY = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk("bp_drain_valid", OUT_VALID, 1);
      chk("bp_drain_result", OUT_RESULT, expq[j]);
      tick();
    end
    chk("bp_no_dup", OUT_VALID, 0);
    chk("bp_in_ready_back", IN_READY, 1);

    // illegal opcode
    send(8'hAA, 8'h55, 3'b110);
    tick();
    chk("ill_result", OUT_RESULT, 0);
    chk("ill_flag", OUT_ILLEGAL, 1);
    chk("ill_zero", OUT_ZERO, 1);
    chk("ill_sel", OUT_SEL, 3'b110);
    tick();
    chk("ill_drained", OUT_VALID, 0);

    // reset mid-stream
    OUT_READY = 1'b0;
    send(8'h01, 8'h01, 3'b000);
    send(8'h02, 8'h01, 3'b000);
    send(8'h03, 8'h01, 3'b000);
    send(8'h04, 8'h01, 3'b000);
    chk("mid_valid", OUT_VALID, 1);
    chk("mid_head", ALU_A, 8'h02);
    #2;
    RST_N = 1'b0;
    #1;
    chk("mid_rst_valid", OUT_VALID, 0);
    chk("mid_rst_result", OUT_RESULT, 0);
    chk("mid_rst_in_ready", IN_READY, 1);
    chk("mid_rst_alu_a", ALU_A, 0);
    @(negedge CLK);
    RST_N     = 1'b1;
    OUT_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_quiet", OUT_VALID, 0);
    end

`ifdef ALU_ISSUE_STATS_EN
    chk("stats_reset", OP_COUNT, 0);
    IN_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IN_A   = 8'(i);
      IN_B   = 8'h01;
      IN_SEL = 3'b000;
      tick();
    end
    IN_VALID = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("stats_ten", OP_COUNT, 16'd10);
    force dut.op_cnt_q = 16'hFFFE;
    #1;
    release dut.op_cnt_q;
    send(8'h01, 8'h01, 3'b000);
    send(8'h02, 8'h01, 3'b000);
    send(8'h03, 8'h01, 3'b000);
    for (int k = 0; k < 4; k++) tick();
    chk("stats_saturate", OP_COUNT, 16'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
